core_run_controller: RTL and testbench
======================================

// Module: core_run_controller
// PURPOSE
//  Parametrised synthesizable run/reset sequencer for rv32i_core bring-up and regression.
//  Holds the core in reset, releases it for up to NUM_RUNS bounded runs with reset gaps between them,
//  and watches the core bus to end each run on a tohost store, PC stall or cycle timeout.
//  Reports pass/fail, cause and cycle counts. Sits between the system reset and the core's reset input.
// PARAMETERS
//  DATA_WIDTH   32           core address/data width
//  NUM_RUNS     2            runs per sequence (>=1)
//  RUN_CYCLES   10000        max cycles per run before timeout (>=2)
//  RESET_CYCLES 10           cycles core_reset_o is held before each run (>=1)
//  STALL_LIMIT  64           consecutive cycles with unchanged ins_address that count as a stall (>=2)
//  TOHOST_ADDR  32'h00001000 store address that ends a run
//  CNT_WIDTH    32           width of the cycle counters
// PORTS
//  clk             in   1           clock
//  reset           in   1           synchronous, active-high reset
//  start_i         in   1           one-cycle pulse that starts or restarts a sequence
//  ins_address_i   in   DATA_WIDTH  core PC (ins_address)
//  RAM_Addr_i      in   DATA_WIDTH  core data address
//  RAM_DATA_i      in   DATA_WIDTH  core store data
//  RAM_rw_i        in   1           core store strobe (1 = write)
//  core_reset_o    out  1           reset to the core (active-high)
//  done_o          out  1           sequence finished
//  pass_o          out  1           every run ended with tohost == 1
//  fail_o          out  1           a run failed
//  fail_cause_o    out  2           00 none, 01 tohost != 1, 10 stall, 11 timeout
//  tohost_value_o  out  DATA_WIDTH  last tohost store data
//  run_index_o     out  RW          current run, RW = max(1, clog2(NUM_RUNS))
//  cycle_count_o   out  CNT_WIDTH   cycles elapsed in the current/last run
//  total_cycles_o  out  CNT_WIDTH   RUN-state cycles summed over the sequence, saturating
// BEHAVIOUR
//  Reset: state IDLE. core_reset_o=1. All other outputs and counters are 0.
//  States: IDLE, HOLD, RUN, DONE.
//  IDLE: core_reset_o=1. On start_i: go to HOLD, clear run_index_o, all flags and all counters.
//  HOLD: core_reset_o=1 for exactly RESET_CYCLES cycles, then RUN. cycle_count_o=0 on entry to RUN.
//  RUN: core_reset_o=0. cycle_count_o and total_cycles_o increment each cycle.
//   The first RUN cycle has cycle_count_o=0.
//   Stall counter: reset to 0 when ins_address_i differs from the previous cycle, else +1.
//   It is cleared on entry to RUN, and the first RUN cycle does not compare.
//   End conditions, evaluated each cycle, priority high to low:
//    1. tohost: RAM_rw_i && RAM_Addr_i==TOHOST_ADDR.
//       Latch tohost_value_o=RAM_DATA_i. Data==1: run passes. Otherwise fail, cause 01.
//    2. stall: stall counter reaches STALL_LIMIT-1. Fail, cause 10.
//    3. timeout: cycle_count_o == RUN_CYCLES-1. Fail, cause 11.
//   On a failing end: fail_o=1, go to DONE next cycle.
//   On a passing end: if run_index_o==NUM_RUNS-1, pass_o=1 and go to DONE. Else run_index_o+1 and go to HOLD.
//   fail_cause_o and fail_o are written on the end cycle and are visible the following cycle.
//  DONE: core_reset_o=1, done_o=1. All results are held. start_i restarts as from IDLE.
//  start_i in HOLD or RUN: abort the sequence and restart. Flags clear, HOLD is re-entered from count 0.
//  reset in any state: returns to the reset values in the next cycle, mid-run included.
//  Counters: cycle_count_o wraps at CNT_WIDTH; this is unreachable when RUN_CYCLES < 2^CNT_WIDTH.
//   total_cycles_o saturates at all-ones.
//  A store to any other address, or a load, has no effect.
//  pass_o and fail_o are never both 1.
// TESTING
//  1. Reset high 3 cycles, no start -> core_reset_o=1, done_o=0, all counters 0.
//  2. NUM_RUNS=2, RESET_CYCLES=10. Stub stores 1 to 0x1000 at run cycle 20, in both runs
//     -> core_reset_o high 10 cycles before each run, pass_o=1, done_o=1, run_index_o=1,
//        cycle_count_o=20, total_cycles_o=42.
//  3. Stub stores 0x0000_0007 to 0x1000 -> fail_o=1, fail_cause_o=01, tohost_value_o=7, pass_o=0.
//  4. PC held at 0x0000_0040 from cycle 5, STALL_LIMIT=64 -> fail_cause_o=10 at cycle 68.
//     A store to 0x1000 on that same cycle wins with cause 00/01.
//  5. PC always advancing, RUN_CYCLES=100 -> fail_cause_o=11, cycle_count_o=99.
//     Reset mid-run at cycle 50 -> all outputs at reset values next cycle.
//  6. start_i pulsed in RUN of run 1 -> run_index_o=0, HOLD restarts, flags cleared.

Source files
------------

// File: rtl/core_run_controller.sv
// Run/reset sequencer for rv32i_core bring-up: holds the core in reset, releases it for bounded
// runs and ends each run on a tohost store, PC stall or timeout, reporting the outcome.
module core_run_controller #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_RUNS     = 2,
  parameter int unsigned RUN_CYCLES   = 10000,
  parameter int unsigned RESET_CYCLES = 10,
  parameter int unsigned STALL_LIMIT  = 64,
  parameter logic [DATA_WIDTH-1:0] TOHOST_ADDR = DATA_WIDTH'(32'h0000_1000),
  parameter int unsigned CNT_WIDTH    = 32,
  localparam int unsigned RW = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] ins_address_i,
  input  logic [DATA_WIDTH-1:0] RAM_Addr_i,
  input  logic [DATA_WIDTH-1:0] RAM_DATA_i,
  input  logic                  RAM_rw_i,
  output logic                  core_reset_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic [1:0]            fail_cause_o,
  output logic [DATA_WIDTH-1:0] tohost_value_o,
  output logic [RW-1:0]         run_index_o,
  output logic [CNT_WIDTH-1:0]  cycle_count_o,
  output logic [CNT_WIDTH-1:0]  total_cycles_o
);

  localparam int unsigned HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned SW = $clog2(STALL_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [SW-1:0]         stall_q, stall_d;
  logic [DATA_WIDTH-1:0] prev_pc_q, prev_pc_d;
  logic                  core_reset_q, core_reset_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic [1:0]            cause_q, cause_d;
  logic [DATA_WIDTH-1:0] tohost_q, tohost_d;
  logic [RW-1:0]         idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]  total_q, total_d;

  logic [SW-1:0] stall_next;
  logic          tohost_hit;
  logic          stall_hit;
  logic          timeout_hit;
  logic          last_run;

  // The first RUN cycle has no previous PC to compare against.
  assign stall_next  = ((cycle_q != '0) && (ins_address_i == prev_pc_q)) ?
                       SW'(stall_q + SW'(1)) : '0;
  assign stall_hit   = (stall_next == SW'(STALL_LIMIT - 1));
  assign tohost_hit  = RAM_rw_i && (RAM_Addr_i == TOHOST_ADDR);
  assign timeout_hit = (cycle_q == CNT_WIDTH'(RUN_CYCLES - 1));
  assign last_run    = (idx_q == RW'(NUM_RUNS - 1));

  // Next-state and result update.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stall_d   = stall_q;
    prev_pc_d = prev_pc_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    cause_d   = cause_q;
    tohost_d  = tohost_q;
    idx_d     = idx_q;
    cycle_d   = cycle_q;
    total_d   = total_q;

    case (state_q)
      S_HOLD: begin
        if (hold_q == HW'(RESET_CYCLES - 1)) begin
          state_d = S_RUN;
          cycle_d = '0;
          stall_d = '0;
        end else begin
          hold_d = HW'(hold_q + HW'(1));
        end
      end
      S_RUN: begin
        prev_pc_d = ins_address_i;
        stall_d   = stall_next;
        if (!(&total_q)) total_d = CNT_WIDTH'(total_q + CNT_WIDTH'(1));
        if (tohost_hit) begin
          tohost_d = RAM_DATA_i;
          if (RAM_DATA_i == DATA_WIDTH'(1)) begin
            if (last_run) begin
              pass_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              idx_d   = RW'(idx_q + RW'(1));
              hold_d  = '0;
              state_d = S_HOLD;
            end
          end else begin
            fail_d  = 1'b1;
            cause_d = 2'b01;
            state_d = S_DONE;
          end
        end else if (stall_hit) begin
          fail_d  = 1'b1;
          cause_d = 2'b10;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          fail_d  = 1'b1;
          cause_d = 2'b11;
          state_d = S_DONE;
        end else begin
          cycle_d = CNT_WIDTH'(cycle_q + CNT_WIDTH'(1));
        end
      end
      default: ;
    endcase

    // A start pulse in any state begins a fresh sequence.
    if (start_i) begin
      state_d  = S_HOLD;
      hold_d   = '0;
      stall_d  = '0;
      pass_d   = 1'b0;
      fail_d   = 1'b0;
      cause_d  = 2'b00;
      tohost_d = '0;
      idx_d    = '0;
      cycle_d  = '0;
      total_d  = '0;
    end
  end

  assign core_reset_d = (state_d != S_RUN);
  assign done_d       = (state_d == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      stall_q      <= '0;
      prev_pc_q    <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      cause_q      <= 2'b00;
      tohost_q     <= '0;
      idx_q        <= '0;
      cycle_q      <= '0;
      total_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      stall_q      <= stall_d;
      prev_pc_q    <= prev_pc_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      cause_q      <= cause_d;
      tohost_q     <= tohost_d;
      idx_q        <= idx_d;
      cycle_q      <= cycle_d;
      total_q      <= total_d;
    end
  end

  assign core_reset_o   = core_reset_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign fail_cause_o   = cause_q;
  assign tohost_value_o = tohost_q;
  assign run_index_o    = idx_q;
  assign cycle_count_o  = cycle_q;
  assign total_cycles_o = total_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Bench for core_run_controller: a behavioural sequence model checked every cycle, directed
// scenarios with literal expectations, then randomized core behaviour with starts and resets.
module tb_core_run_controller;

  localparam int unsigned NR  = 2;
  localparam int unsigned RC  = 100;
  localparam int unsigned RSC = 10;
  localparam int unsigned SL  = 64;
  localparam int unsigned CW  = 7;
  localparam int          MAXC = (1 << CW) - 1;
  localparam logic [31:0] TH  = 32'h0000_1000;

  localparam int PH_IDLE = 0, PH_HOLD = 1, PH_RUN = 2, PH_DONE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] ins_address_i = '0;
  logic [31:0] RAM_Addr_i = '0;
  logic [31:0] RAM_DATA_i = '0;
  logic        RAM_rw_i = 1'b0;

  logic          core_reset_o, done_o, pass_o, fail_o;
  logic [1:0]    fail_cause_o;
  logic [31:0]   tohost_value_o;
  logic [0:0]    run_index_o;
  logic [CW-1:0] cycle_count_o, total_cycles_o;

  core_run_controller #(
    .DATA_WIDTH(32), .NUM_RUNS(NR), .RUN_CYCLES(RC), .RESET_CYCLES(RSC),
    .STALL_LIMIT(SL), .TOHOST_ADDR(TH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .ins_address_i(ins_address_i), .RAM_Addr_i(RAM_Addr_i), .RAM_DATA_i(RAM_DATA_i),
    .RAM_rw_i(RAM_rw_i),
    .core_reset_o(core_reset_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
    .fail_cause_o(fail_cause_o), .tohost_value_o(tohost_value_o), .run_index_o(run_index_o),
    .cycle_count_o(cycle_count_o), .total_cycles_o(total_cycles_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Core stub program: 0 advancing PC, 1 store at st_cyc, 2 PC parked at 0x40 from cycle 5, 3 random.
  int          prog = 0;
  int          st_cyc = -1;
  logic [31:0] st_val = 32'd1;
  int          r_freeze = 200;
  int          r_store = 200;
  logic [31:0] r_val = 32'd1;

  // Behavioural model: phase, elapsed cycles, and where the current identical-PC streak began.
  int          m_ph = PH_IDLE;
  int          m_hold = 0;
  int          m_cyc = 0;
  int          m_total = 0;
  int          m_idx = 0;
  int          m_same_since = 0;
  int          m_cause = 0;
  bit          m_pass = 1'b0;
  bit          m_fail = 1'b0;
  logic [31:0] m_last_pc = '0;
  logic [31:0] m_tohost = '0;

  task automatic model_clear();
    m_cyc = 0; m_total = 0; m_idx = 0; m_cause = 0;
    m_pass = 1'b0; m_fail = 1'b0; m_tohost = '0;
  endtask

  task automatic model_end_fail(input int c);
    m_fail = 1'b1; m_cause = c; m_ph = PH_DONE;
  endtask

  task automatic model_end_pass();
    if (m_idx == NR - 1) begin
      m_pass = 1'b1; m_ph = PH_DONE;
    end else begin
      m_idx++; m_hold = 0; m_ph = PH_HOLD;
    end
  endtask

  task automatic model_run_cycle();
    int k;
    k = m_cyc;
    if (k == 0 || ins_address_i != m_last_pc) m_same_since = k;
    m_last_pc = ins_address_i;
    m_total = (m_total + 1 > MAXC) ? MAXC : m_total + 1;
    if (RAM_rw_i && RAM_Addr_i == TH) begin
      m_tohost = RAM_DATA_i;
      if (RAM_DATA_i == 32'd1) model_end_pass();
      else model_end_fail(1);
    end else if (k - m_same_since == SL - 1) begin
      model_end_fail(2);
    end else if (k == RC - 1) begin
      model_end_fail(3);
    end else begin
      m_cyc = k + 1;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_ph = PH_IDLE; model_clear();
    end else if (start_i) begin
      m_ph = PH_HOLD; m_hold = 0; model_clear();
    end else if (m_ph == PH_HOLD) begin
      m_hold++;
      if (m_hold == RSC) begin
        m_ph = PH_RUN; m_cyc = 0;
      end
    end else if (m_ph == PH_RUN) begin
      model_run_cycle();
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("core_reset_o", core_reset_o, m_ph != PH_RUN);
    check("done_o", done_o, m_ph == PH_DONE);
    check("pass_o", pass_o, m_pass);
    check("fail_o", fail_o, m_fail);
    check("fail_cause_o", fail_cause_o, m_cause);
    check("tohost_value_o", tohost_value_o, m_tohost);
    check("run_index_o", run_index_o, m_idx);
    check("cycle_count_o", cycle_count_o, m_cyc);
    check("total_cycles_o", total_cycles_o, m_total);
  endtask

  task automatic put_store(input logic [31:0] v);
    RAM_rw_i = 1'b1; RAM_Addr_i = TH; RAM_DATA_i = v;
  endtask

  task automatic drive_core();
    int k;
    ins_address_i = '0; RAM_Addr_i = '0; RAM_DATA_i = '0; RAM_rw_i = 1'b0;
    if (m_ph == PH_RUN) begin
      k = m_cyc;
      case (prog)
        0: ins_address_i = 32'(32'h100 + 4 * k);
        1: begin
          ins_address_i = 32'(32'h100 + 4 * k);
          if (k == st_cyc) put_store(st_val);
        end
        2: begin
          ins_address_i = (k < 5) ? 32'(32'h100 + 4 * k) : 32'h40;
          if (k == st_cyc) put_store(st_val);
        end
        default: begin
          if (k == 0) begin
            r_freeze = int'($urandom_range(1, 150));
            r_store  = int'($urandom_range(0, 140));
            r_val    = ($urandom_range(0, 3) != 0) ? 32'd1 : 32'($urandom);
          end
          ins_address_i = (k < r_freeze) ? 32'(32'h200 + 4 * k) : 32'h3f0;
          if ($urandom_range(0, 7) == 0) begin
            RAM_DATA_i = 32'd1;
            if ($urandom_range(0, 1) == 1) RAM_Addr_i = TH;
            else begin
              RAM_Addr_i = $urandom | 32'h0001_0000;
              RAM_rw_i   = 1'b1;
            end
          end
          if (k == r_store) put_store(r_val);
        end
      endcase
    end
  endtask

  // One cycle: check outputs mid-cycle, then drive the inputs for the next edge.
  task automatic tick(input bit st, input bit rs);
    @(negedge clk);
    compare_all();
    drive_core();
    start_i = st;
    reset   = rs;
  endtask

  task automatic start_seq();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic wait_done(output int low);
    int n;
    n = 0; low = 0;
    while (m_ph != PH_DONE && n < 400) begin
      tick(1'b0, 1'b0);
      n++;
      if (core_reset_o === 1'b0) low++;
    end
    check("done_reached", done_o, 1);
  endtask

  initial begin
    int low;
    int n;

    // Reset held, no start.
    repeat (3) tick(1'b0, 1'b1);
    check("t1_core_reset", core_reset_o, 1);
    check("t1_done", done_o, 0);
    check("t1_cycles", cycle_count_o, 0);
    check("t1_total", total_cycles_o, 0);
    tick(1'b0, 1'b0);

    // Two passing runs, tohost=1 at run cycle 20.
    prog = 1; st_cyc = 20; st_val = 32'd1;
    start_seq();
    wait_done(low);
    check("t2_pass", pass_o, 1);
    check("t2_fail", fail_o, 0);
    check("t2_run_index", run_index_o, 1);
    check("t2_cycles", cycle_count_o, 20);
    check("t2_total", total_cycles_o, 42);
    check("t2_run_low_cycles", low, 42);

    // tohost != 1.
    st_val = 32'd7;
    start_seq();
    wait_done(low);
    check("t3_fail", fail_o, 1);
    check("t3_cause", fail_cause_o, 2'b01);
    check("t3_tohost", tohost_value_o, 7);
    check("t3_pass", pass_o, 0);

    // PC stall from cycle 5.
    prog = 2; st_cyc = -1;
    start_seq();
    wait_done(low);
    check("t4_cause", fail_cause_o, 2'b10);
    check("t4_cycles", cycle_count_o, 68);
    check("t4_total", total_cycles_o, 69);

    // tohost=1 on the stall cycle wins in both runs; total saturates.
    st_cyc = 68; st_val = 32'd1;
    start_seq();
    wait_done(low);
    check("t4b_pass", pass_o, 1);
    check("t4b_cause", fail_cause_o, 2'b00);
    check("t4b_total_sat", total_cycles_o, MAXC);

    st_val = 32'd9;
    start_seq();
    wait_done(low);
    check("t4c_cause", fail_cause_o, 2'b01);
    check("t4c_tohost", tohost_value_o, 9);
    check("t4c_cycles", cycle_count_o, 68);

    // Timeout.
    prog = 0;
    start_seq();
    wait_done(low);
    check("t5_cause", fail_cause_o, 2'b11);
    check("t5_cycles", cycle_count_o, 99);
    check("t5_total", total_cycles_o, 100);

    // Reset mid-run at cycle 50.
    start_seq();
    n = 0;
    while (!(m_ph == PH_RUN && m_cyc == 50) && n < 300) begin tick(1'b0, 1'b0); n++; end
    check("t5b_in_run", core_reset_o, 0);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    check("t5b_core_reset", core_reset_o, 1);
    check("t5b_cycles", cycle_count_o, 0);
    check("t5b_total", total_cycles_o, 0);
    check("t5b_fail", fail_o, 0);

    // Start pulse during run 1 aborts and restarts.
    prog = 1; st_cyc = 20; st_val = 32'd1;
    start_seq();
    n = 0;
    while (!(m_ph == PH_RUN && m_idx == 1 && m_cyc == 10) && n < 300) begin tick(1'b0, 1'b0); n++; end
    check("t6_in_run1", run_index_o, 1);
    start_i = 1'b1;
    tick(1'b0, 1'b0);
    check("t6_run_index", run_index_o, 0);
    check("t6_core_reset", core_reset_o, 1);
    check("t6_total", total_cycles_o, 0);
    check("t6_done", done_o, 0);
    wait_done(low);
    check("t6_pass", pass_o, 1);
    check("t6_total_end", total_cycles_o, 42);

    // Randomized core behaviour with sporadic starts and resets.
    prog = 3;
    for (int i = 0; i < 6000; i++) begin
      bit st, rs;
      st = (m_ph == PH_IDLE || m_ph == PH_DONE) ? ($urandom_range(0, 3) == 0)
                                                 : ($urandom_range(0, 299) == 0);
      rs = ($urandom_range(0, 1999) == 0);
      tick(st, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
